// File: rtl/strobe_pkg.sv
// Shared definitions for the enable-strobe generator: FSM encoding, default
// periods and the period-select mux.
package strobe_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   localparam int unsigned DEF_NB_COUNT = 32;
   localparam int unsigned DEF_NB_BURST = 8;
   localparam int unsigned DEF_PERIOD_0 = 4;
   localparam int unsigned DEF_PERIOD_1 = 16;
   localparam int unsigned DEF_PERIOD_2 = 256;
   localparam int unsigned DEF_PERIOD_3 = 50_000_000;

   function automatic logic [31:0] select_period(
      input logic [1:0]  sel,
      input logic [31:0] p0,
      input logic [31:0] p1,
      input logic [31:0] p2,
      input logic [31:0] p3
   );
      logic [31:0] result;
      case (sel)
         2'd0:    result = p0;
         2'd1:    result = p1;
         2'd2:    result = p2;
         default: result = p3;
      endcase
      return result;
   endfunction

endpackage

// File: rtl/strobe_prescaler.sv
// Free-running period counter: counts 0..period-1 while run is high and flags
// the terminal count for exactly the cycle in which the counter sits at period-1.
module strobe_prescaler #(
   parameter int unsigned NB_COUNT = 32
) (
   input  logic                clock,
   input  logic                i_reset,
   input  logic                clear,
   input  logic                run,
   input  logic [NB_COUNT-1:0] period,
   output logic                o_tc
);

   logic [NB_COUNT-1:0] count_q;
   logic [NB_COUNT-1:0] count_d;
   logic [NB_COUNT-1:0] period_m1;

   assign period_m1 = period - NB_COUNT'(1);
   assign o_tc      = run && (count_q == period_m1);

   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (run) begin
         count_d = o_tc ? '0 : count_q + NB_COUNT'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (!i_reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/strobe_gen.sv
// Programmable enable-strobe generator: single-cycle o_enable pulses at one of
// four periods, as a finite burst or continuously, under start/stop control.
module strobe_gen
   import strobe_pkg::*;
#(
   parameter int unsigned NB_COUNT = DEF_NB_COUNT,
   parameter int unsigned NB_BURST = DEF_NB_BURST,
   parameter int unsigned PERIOD_0 = DEF_PERIOD_0,
   parameter int unsigned PERIOD_1 = DEF_PERIOD_1,
   parameter int unsigned PERIOD_2 = DEF_PERIOD_2,
   parameter int unsigned PERIOD_3 = DEF_PERIOD_3
) (
   input  logic                clock,
   input  logic                i_reset,
   input  logic                i_start,
   input  logic                i_stop,
   input  logic [1:0]          i_sel,
   input  logic [NB_BURST-1:0] i_burst,
   output logic                o_enable,
   output logic                o_busy,
   output logic                o_done,
   output logic [NB_BURST-1:0] o_pulse_cnt
);

   state_e              state_q;
   state_e              state_d;
   logic [NB_COUNT-1:0] period_q;
   logic [NB_COUNT-1:0] period_d;
   logic [NB_BURST-1:0] burst_q;
   logic [NB_BURST-1:0] burst_d;
   logic [NB_BURST-1:0] pulse_cnt_q;
   logic [NB_BURST-1:0] pulse_cnt_d;
   logic                enable_q;
   logic                enable_d;
   logic                busy_q;
   logic                busy_d;
   logic                done_q;
   logic                done_d;

   logic                presc_clear;
   logic                presc_run;
   logic                presc_tc;

   // A stop in RUN must also suppress a strobe on a matching edge, so it gates run.
   assign presc_clear = (state_q != ST_RUN);
   assign presc_run   = (state_q == ST_RUN) && !i_stop;

   strobe_prescaler #(
      .NB_COUNT (NB_COUNT)
   ) u_prescaler (
      .clock   (clock),
      .i_reset (i_reset),
      .clear   (presc_clear),
      .run     (presc_run),
      .period  (period_q),
      .o_tc    (presc_tc)
   );

   always_comb begin
      state_d     = state_q;
      period_d    = period_q;
      burst_d     = burst_q;
      pulse_cnt_d = pulse_cnt_q;
      enable_d    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (i_start && !i_stop) begin
               state_d     = ST_RUN;
               period_d    = NB_COUNT'(select_period(i_sel, PERIOD_0, PERIOD_1,
                                                     PERIOD_2, PERIOD_3));
               burst_d     = i_burst;
               pulse_cnt_d = '0;
            end
         end
         ST_RUN: begin
            if (i_stop) begin
               state_d = ST_IDLE;
            end else if (presc_tc) begin
               enable_d    = 1'b1;
               pulse_cnt_d = pulse_cnt_q + NB_BURST'(1);
               // A latched burst of zero means continuous: the count simply wraps.
               if ((burst_q != '0) && (pulse_cnt_d == burst_q)) begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d == ST_RUN);
      done_d = (state_d == ST_DONE);
   end

   always_ff @(posedge clock) begin
      if (!i_reset) begin
         state_q     <= ST_IDLE;
         period_q    <= '0;
         burst_q     <= '0;
         pulse_cnt_q <= '0;
         enable_q    <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         period_q    <= period_d;
         burst_q     <= burst_d;
         pulse_cnt_q <= pulse_cnt_d;
         enable_q    <= enable_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign o_enable    = enable_q;
   assign o_busy      = busy_q;
   assign o_done      = done_q;
   assign o_pulse_cnt = pulse_cnt_q;

endmodule

// File: tb/tb_strobe_gen.sv
// Scoreboard bench for strobe_gen: each issued start schedules its expected
// strobes; a monitor pops and compares whenever the DUT strobes.
module tb_strobe_gen;

   logic       clock;
   logic       i_reset;
   logic       i_start;
   logic       i_stop;
   logic [1:0] i_sel;
   logic [7:0] i_burst;
   logic       o_enable;
   logic       o_busy;
   logic       o_done;
   logic [7:0] o_pulse_cnt;

   typedef struct {
      int at_edge;
      int cnt;
      bit done;
   } ev_t;

   ev_t exp_q[$];

   int checks      = 0;
   int errors      = 0;
   int edge_n      = 0;
   int next_start  = 0;
   int start_edge  = -1;
   int reset_edge  = -1;
   int busy_from   = 0;
   int busy_until  = 0;
   int exp_cnt     = 0;
   bit monitor_on  = 0;

   strobe_gen #(
      .PERIOD_3 (6)
   ) dut (
      .clock       (clock),
      .i_reset     (i_reset),
      .i_start     (i_start),
      .i_stop      (i_stop),
      .i_sel       (i_sel),
      .i_burst     (i_burst),
      .o_enable    (o_enable),
      .o_busy      (o_busy),
      .o_done      (o_done),
      .o_pulse_cnt (o_pulse_cnt)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   always @(posedge clock) edge_n <= edge_n + 1;

   function automatic int ref_period(input logic [1:0] sel);
      case (sel)
         2'd0:    return 4;
         2'd1:    return 16;
         2'd2:    return 256;
         default: return 6;
      endcase
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s at edge %0d: got %0d expected %0d",
                  name, edge_n, actual, expected);
      end
   endtask

   // Issue one start with the given settings; stop_off > 0 stops at start+stop_off.
   task automatic applyStimulus(input logic [1:0] sel, input logic [7:0] burst,
                                input int stop_off, input bit noise);
      int  p;
      int  t;
      int  s;
      int  last;
      bit  stopped;
      ev_t ev;
      while (edge_n + 1 < next_start) @(negedge clock);
      p       = ref_period(sel);
      t       = edge_n + 1;
      stopped = (stop_off > 0);
      s       = t + stop_off;
      last    = t + int'(burst) * p;
      for (int k = 1; k < 100000; k++) begin
         if (burst != 0 && k > int'(burst)) break;
         if (stopped && t + k * p >= s) break;
         ev.at_edge = t + k * p;
         ev.cnt     = k % 256;
         ev.done    = (burst != 0) && (k == int'(burst));
         exp_q.push_back(ev);
      end
      start_edge = t;
      busy_from  = t;
      busy_until = stopped ? s : last;
      next_start = stopped ? s + 1 : last + 2;
      i_sel   = sel;
      i_burst = burst;
      i_start = 1'b1;
      i_stop  = 1'b0;
      @(negedge clock);
      i_start = 1'b0;
      while (edge_n + 1 < next_start) begin
         i_stop  = stopped && (edge_n + 1 == s);
         i_start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
         if (noise) begin
            i_sel   = 2'($urandom);
            i_burst = 8'($urandom);
         end
         @(negedge clock);
      end
      i_start = 1'b0;
      i_stop  = 1'b0;
   endtask

   task automatic resetMidBurst();
      int  t;
      int  r;
      ev_t ev;
      while (edge_n + 1 < next_start) @(negedge clock);
      t = edge_n + 1;
      r = t + 9;
      for (int k = 1; k <= 2; k++) begin
         ev.at_edge = t + 4 * k;
         ev.cnt     = k;
         ev.done    = 1'b0;
         exp_q.push_back(ev);
      end
      start_edge = t;
      reset_edge = r;
      busy_from  = t;
      busy_until = r;
      next_start = r + 1;
      i_sel   = 2'd0;
      i_burst = 8'd5;
      i_start = 1'b1;
      @(negedge clock);
      i_start = 1'b0;
      while (edge_n + 1 < r) @(negedge clock);
      i_reset = 1'b0;
      @(negedge clock);
      i_reset = 1'b1;
      checkOutput("reset_mid_burst_outputs",
                  {21'd0, o_enable, o_busy, o_done, o_pulse_cnt}, 32'd0);
   endtask

   task automatic idleStartStop();
      while (edge_n + 1 < next_start) @(negedge clock);
      i_start = 1'b1;
      i_stop  = 1'b1;
      i_sel   = 2'd0;
      i_burst = 8'd1;
      @(negedge clock);
      i_start = 1'b0;
      i_stop  = 1'b0;
      repeat (8) @(negedge clock);
      checkOutput("idle_start_stop_busy", {31'd0, o_busy}, 32'd0);
   endtask

   // Monitor: compare every strobe with the scoreboard and track busy/count.
   initial begin
      ev_t ev;
      forever begin
         @(negedge clock);
         if (monitor_on) begin
            if (edge_n == start_edge || edge_n == reset_edge) exp_cnt = 0;
            if (o_enable || o_done) begin
               if (exp_q.size() == 0) begin
                  checkOutput("unexpected_strobe", {30'd0, o_done, o_enable}, 32'd0);
               end else begin
                  ev = exp_q.pop_front();
                  checkOutput("strobe_edge", edge_n, ev.at_edge);
                  checkOutput("strobe_enable", {31'd0, o_enable}, 32'd1);
                  checkOutput("strobe_done", {31'd0, o_done}, {31'd0, ev.done});
                  exp_cnt = ev.cnt;
               end
            end else if (exp_q.size() != 0 && exp_q[0].at_edge < edge_n) begin
               ev = exp_q.pop_front();
               checkOutput("missed_strobe_edge", edge_n, ev.at_edge);
            end
            checkOutput("busy", {31'd0, o_busy},
                        {31'd0, (edge_n >= busy_from) && (edge_n < busy_until)});
            checkOutput("pulse_cnt", {24'd0, o_pulse_cnt}, exp_cnt);
         end
      end
   end

   initial begin
      #(1_000_000);
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      logic [1:0] sel;
      logic [7:0] burst;
      int         stop_off;
      int         p;
      i_reset = 1'b0;
      i_start = 1'b0;
      i_stop  = 1'b0;
      i_sel   = 2'd0;
      i_burst = 8'd0;
      repeat (2) @(negedge clock);
      checkOutput("reset_state",
                  {21'd0, o_enable, o_busy, o_done, o_pulse_cnt}, 32'd0);
      i_reset    = 1'b1;
      next_start = edge_n + 1;
      monitor_on = 1'b1;
      $display("[TB] reset released at edge %0d", edge_n);

      resetMidBurst();
      applyStimulus(2'd0, 8'd3, 0, 1'b0);
      applyStimulus(2'd0, 8'd10, 10, 1'b0);
      applyStimulus(2'd0, 8'd10, 12, 1'b0);
      idleStartStop();
      applyStimulus(2'd0, 8'd4, 0, 1'b1);
      applyStimulus(2'd3, 8'd2, 0, 1'b0);
      applyStimulus(2'd1, 8'd0, 16 * 258 + 5, 1'b0);
      idleStartStop();

      for (int n = 0; n < 40; n++) begin
         sel = 2'($urandom);
         p   = ref_period(sel);
         if ($urandom_range(0, 3) == 0) begin
            burst    = 8'd0;
            stop_off = 1 + int'($urandom_range(0, 3 * p - 1));
         end else begin
            burst    = (sel == 2'd2) ? 8'($urandom_range(1, 2)) : 8'($urandom_range(1, 6));
            stop_off = ($urandom_range(0, 2) == 0) ?
                       1 + int'($urandom_range(0, int'(burst) * p - 1)) : 0;
         end
         repeat ($urandom_range(0, 2)) @(negedge clock);
         applyStimulus(sel, burst, stop_off, 1'($urandom_range(0, 1)));
      end

      while (edge_n + 1 < next_start + 4) @(negedge clock);
      checkOutput("scoreboard_empty", exp_q.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
